// File: rtl/riscv_pkg.sv
// Shared RV32I control definitions: FSM state codes, opcodes, ALU control
// codes, ALU operation classes and datapath mux-select encodings.
package riscv_pkg;

  // Controller state register encoding (4 bits).
  typedef logic [3:0] state_t;

  localparam state_t StFetch    = 4'd0;
  localparam state_t StDecode   = 4'd1;
  localparam state_t StMemAdr   = 4'd2;
  localparam state_t StMemRead  = 4'd3;
  localparam state_t StMemWb    = 4'd4;
  localparam state_t StMemWrite = 4'd5;
  localparam state_t StExecR    = 4'd6;
  localparam state_t StExecI    = 4'd7;
  localparam state_t StAluWb    = 4'd8;
  localparam state_t StBeq      = 4'd9;
  localparam state_t StJal      = 4'd10;
  localparam state_t StHalt     = 4'd11;

  // Opcodes (instr[6:0]).
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  // ALU control codes.
  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  // Class of ALU operation requested by the FSM.
  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } alu_op_e;

  // ALU source A select.
  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  // ALU source B select.
  localparam logic [1:0] SrcBRs2   = 2'b00;
  localparam logic [1:0] SrcBImm   = 2'b01;
  localparam logic [1:0] SrcBFour  = 2'b10;

  // Result bus select.
  localparam logic [1:0] ResAluOut = 2'b00;
  localparam logic [1:0] ResData   = 2'b01;
  localparam logic [1:0] ResAlu    = 2'b10;

  // Immediate format select.
  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decoder.
// Ports:
//   i_op        instruction opcode (bit 5 distinguishes R-type from I-type)
//   i_funct3    instr[14:12]
//   i_funct7b5  instr[30]
//   i_alu_op    operation class from the FSM (add, sub, decode funct)
//   o_alu_control  3-bit ALU operation code
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  alu_op_e    i_alu_op,
  output logic [2:0] o_alu_control
);

  logic w_is_sub;

  // instr[30] only means subtract for R-type; addi with imm[10] set stays add.
  assign w_is_sub = i_op[5] & i_funct7b5;

  always_comb begin
    o_alu_control = AluAdd;
    unique case (i_alu_op)
      AluOpAdd: o_alu_control = AluAdd;
      AluOpSub: o_alu_control = AluSub;
      AluOpFunct: begin
        case (i_funct3)
          3'b000:  o_alu_control = w_is_sub ? AluSub : AluAdd;
          3'b010:  o_alu_control = AluSlt;
          3'b110:  o_alu_control = AluOr;
          3'b111:  o_alu_control = AluAnd;
          default: o_alu_control = AluAdd;
        endcase
      end
      default: o_alu_control = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore FSM sequencing fetch, decode, memory,
// execute, writeback, branch and jump steps, plus ALU and immediate decode.
// Ports:
//   clk, rst (async, active-low)
//   op, funct3, funct7b5   instruction fields from the instruction register
//   zero                   ALU zero flag (branch condition)
//   mem_ready              memory completes the current request this cycle
//   mem_req, mem_write, adr_src       memory interface controls
//   ir_write, pc_write, reg_write     architectural state enables
//   alu_src_a, alu_src_b, result_src  datapath mux selects
//   imm_src, alu_control              immediate format and ALU operation
//   illegal                flag: halted on an unknown opcode
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal
);

  state_t  r_state;
  state_t  w_state_next;
  alu_op_e w_alu_op;
  logic    w_mem_req;
  logic    w_mem_write;
  logic    w_ir_write;
  logic    w_pc_write;
  logic    w_reg_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StFetch:    w_state_next = mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (op)
          OpLoad, OpStore: w_state_next = StMemAdr;
          OpR:             w_state_next = StExecR;
          OpI:             w_state_next = StExecI;
          OpBeq:           w_state_next = StBeq;
          OpJal:           w_state_next = StJal;
          default:         w_state_next = StHalt;
        endcase
      end
      StMemAdr:   w_state_next = (op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  w_state_next = mem_ready ? StMemWb : StMemRead;
      StMemWb:    w_state_next = StFetch;
      StMemWrite: w_state_next = mem_ready ? StFetch : StMemWrite;
      StExecR:    w_state_next = StAluWb;
      StExecI:    w_state_next = StAluWb;
      StAluWb:    w_state_next = StFetch;
      StBeq:      w_state_next = StFetch;
      StJal:      w_state_next = StAluWb;
      StHalt:     w_state_next = StHalt;
      default:    w_state_next = StHalt;
    endcase
  end

  always_comb begin
    w_mem_req   = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_reg_write = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = SrcAPc;
    alu_src_b   = SrcBRs2;
    result_src  = ResAluOut;
    w_alu_op    = AluOpAdd;
    case (r_state)
      StFetch: begin
        w_mem_req  = 1'b1;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        alu_src_a  = SrcAPc;
        alu_src_b  = SrcBFour;
        result_src = ResAlu;
      end
      StDecode: begin
        // Precompute the branch target into ALUOut.
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
      end
      StMemAdr: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
      end
      StMemRead: begin
        w_mem_req = 1'b1;
        adr_src   = 1'b1;
      end
      StMemWb: begin
        result_src  = ResData;
        w_reg_write = 1'b1;
      end
      StMemWrite: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        adr_src     = 1'b1;
      end
      StExecR: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBRs2;
        w_alu_op  = AluOpFunct;
      end
      StExecI: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
        w_alu_op  = AluOpFunct;
      end
      StAluWb: begin
        result_src  = ResAluOut;
        w_reg_write = 1'b1;
      end
      StBeq: begin
        alu_src_a  = SrcARs1;
        alu_src_b  = SrcBRs2;
        w_alu_op   = AluOpSub;
        result_src = ResAluOut;
        w_pc_write = zero;
      end
      StJal: begin
        alu_src_a  = SrcAOldPc;
        alu_src_b  = SrcBFour;
        result_src = ResAluOut;
        w_pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are gated by rst so an asserted reset silences them immediately,
  // independent of mem_ready/zero qualifiers.
  assign mem_req   = w_mem_req & rst;
  assign mem_write = w_mem_write & w_mem_req & rst;
  assign ir_write  = w_ir_write & rst;
  assign pc_write  = w_pc_write & rst;
  assign reg_write = w_reg_write & rst;
  assign illegal   = (r_state == StHalt);

  always_comb begin
    imm_src = ImmI;
    case (op)
      OpStore: imm_src = ImmS;
      OpBeq:   imm_src = ImmB;
      OpJal:   imm_src = ImmJ;
      default: imm_src = ImmI;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_op          (op),
    .i_funct3      (funct3),
    .i_funct7b5    (funct7b5),
    .i_alu_op      (w_alu_op),
    .o_alu_control (alu_control)
  );

endmodule
